aes_output_arbiter: RTL and testbench

- Shares one 32-bit result output port between NUM_REQ AES cores.
- Each core raises a request with a finished 128-bit text block. The arbiter grants one core at a time, round-robin, and latches that core's block.
- It then streams the block as four 32-bit words, least significant word first, using a valid/ready handshake.
- It sits between the AES core array and the host result interface, and sequences result draining for the whole array.

---
 rtl/aes_output_arbiter.sv | 124 ++++++++++++
 tb/tb_aes_output_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_output_arbiter.sv
// Round-robin arbiter that drains finished 128-bit AES blocks from NUM_REQ cores
// onto a shared 32-bit valid/ready result port, least significant word first.
module aes_output_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_i,
  input  logic [128*NUM_REQ-1:0] text_i,
  output logic [NUM_REQ-1:0]     ack_o,
  output logic [31:0]            text_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [1:0]             word_idx_o,
  output logic [1:0]             src_o,
  output logic                   last_o,
  output logic                   busy_o
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t               state_q, state_d;
  logic [127:0]         buf_q, buf_d;
  logic [1:0]           idx_q, idx_d;
  logic [1:0]           src_q, src_d;
  logic [1:0]           lg_q, lg_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;

  logic [3:0]           req_ext;
  logic [127:0]         text_arr [4];
  logic [NUM_REQ-1:0]   ack_onehot;
  logic                 found;
  logic [1:0]           grant;
  logic [2:0]           cand;

  // Pad the per-core vectors to four slots so the grant index is always 2 bits.
  for (genvar gi = 0; gi < 4; gi++) begin : g_pad
    if (gi < NUM_REQ) begin : g_used
      assign req_ext[gi]  = req_i[gi];
      assign text_arr[gi] = text_i[128*gi +: 128];
    end else begin : g_unused
      assign req_ext[gi]  = 1'b0;
      assign text_arr[gi] = '0;
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ack
    assign ack_onehot[gi] = (grant == 2'(gi));
  end

  // Search starts one past the previous winner and wraps at NUM_REQ.
  always_comb begin
    grant = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = {1'b0, lg_q} + 3'(i);
      if (cand >= 3'(NUM_REQ)) cand = cand - 3'(NUM_REQ);
      if (!found && req_ext[cand[1:0]]) begin
        found = 1'b1;
        grant = cand[1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    idx_d   = idx_q;
    src_d   = src_q;
    lg_d    = lg_q;
    ack_d   = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          buf_d   = text_arr[grant];
          src_d   = grant;
          lg_d    = grant;
          idx_d   = 2'd0;
          ack_d   = ack_onehot;
          state_d = SEND;
        end
      end
      SEND: begin
        if (ready_i) begin
          if (idx_q == 2'd3) begin
            state_d = IDLE;
            idx_d   = 2'd0;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      buf_q   <= '0;
      idx_q   <= 2'd0;
      src_q   <= 2'd0;
      lg_q    <= 2'(NUM_REQ-1);
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
      src_q   <= src_d;
      lg_q    <= lg_d;
      ack_q   <= ack_d;
    end
  end

  assign valid_o    = (state_q == SEND);
  assign busy_o     = (state_q != IDLE);
  assign text_o     = valid_o ? buf_q[{idx_q, 5'd0} +: 32] : 32'd0;
  assign last_o     = valid_o && (idx_q == 2'd3);
  assign word_idx_o = idx_q;
  assign src_o      = src_q;
  assign ack_o      = ack_q;

endmodule

// File: tb/tb_aes_output_arbiter.sv
// Bench for aes_output_arbiter: transaction-level model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_aes_output_arbiter;
  localparam int N = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req_i = '0;
  logic [128*N-1:0] text_i = '0;
  logic             ready_i = 1'b1;
  logic [N-1:0]     ack_o;
  logic [31:0]      text_o;
  logic             valid_o, last_o, busy_o;
  logic [1:0]       word_idx_o, src_o;

  aes_output_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .text_i(text_i), .ack_o(ack_o),
    .text_o(text_o), .valid_o(valid_o), .ready_i(ready_i),
    .word_idx_o(word_idx_o), .src_o(src_o), .last_o(last_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a block is a list of four words; one word leaves per accepted beat.
  logic         m_busy = 1'b0;
  logic [31:0]  m_words [4];
  int           m_idx = 0, m_src = 0, m_lg = N-1, m_g;
  logic [N-1:0] m_ack = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0; m_idx = 0; m_src = 0; m_lg = N-1; m_ack = '0;
    end else if (!m_busy) begin
      m_ack = '0;
      if (req_i != '0) begin
        m_g = -1;
        for (int i = 1; i <= N; i++)
          if (m_g < 0 && req_i[(m_lg+i)%N]) m_g = (m_lg+i)%N;
        for (int w = 0; w < 4; w++) m_words[w] = text_i[128*m_g+32*w +: 32];
        m_busy = 1'b1; m_idx = 0; m_src = m_g; m_lg = m_g; m_ack[m_g] = 1'b1;
      end
    end else begin
      m_ack = '0;
      if (ready_i) begin
        if (m_idx == 3) begin m_busy = 1'b0; m_idx = 0; end
        else m_idx++;
      end
    end
  end

  logic        last_valid = 1'b0;
  logic [31:0] last_text = '0;
  logic [31:0] seen [$];

  always @(negedge clk) begin
    chk("valid", valid_o, m_busy);
    chk("busy", busy_o, m_busy);
    chk("ack", ack_o, m_ack);
    chk("text", text_o, m_busy ? m_words[m_idx] : 32'd0);
    chk("word_idx", word_idx_o, m_idx);
    chk("src", src_o, m_src);
    chk("last", last_o, m_busy && (m_idx == 3));
    last_valid = valid_o;
    last_text  = text_o;
  end

  // Words accepted by the downstream, in the order they were handed over.
  always @(posedge clk) begin
    if (!rst && last_valid && ready_i) seen.push_back(last_text);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_i = '0; ready_i = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_ack(output int cyc);
    cyc = 0;
    do begin tick(); cyc++; end while (ack_o == '0 && cyc < 20);
    chk("ack_timeout", (cyc >= 20), 1'b0);
  endtask

  localparam logic [127:0] BLK0 = 128'h33333333_22222222_11111111_00000000;
  localparam logic [127:0] BLK1 = 128'hdddddddd_cccccccc_bbbbbbbb_aaaaaaaa;

  logic [31:0] exp_w [4];
  int          cyc, g;
  int          waited [N];
  int          grants [4];

  initial begin
    exp_w[0] = 32'h00000000; exp_w[1] = 32'h11111111;
    exp_w[2] = 32'h22222222; exp_w[3] = 32'h33333333;

    // Reset state and single request
    tick(); tick();
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_text", text_o, 32'd0);
    rst = 1'b0;
    tick();
    text_i[127:0] = BLK0;
    req_i = 4'b0001;
    tick();
    req_i = '0;
    chk("single_ack", ack_o, 4'b0001);
    chk("single_src", src_o, 2'd0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("single_word%0d", i), text_o, exp_w[i]);
      chk($sformatf("single_last%0d", i), last_o, (i == 3));
      tick();
      if (i == 0) chk("single_ack_drop", ack_o, 4'b0000);
    end
    chk("single_done", valid_o, 1'b0);
    $display("single request: %0d words accepted", seen.size());

    // Back-pressure at word 1
    seen.delete();
    req_i = 4'b0001;
    tick();
    req_i = '0;
    tick();
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_text", text_o, 32'h11111111);
      chk("bp_hold_idx", word_idx_o, 2'd1);
    end
    ready_i = 1'b1;
    tick(); tick(); tick();
    chk("bp_done", valid_o, 1'b0);
    chk("bp_handshakes", seen.size(), 4);
    for (int i = 0; i < 4 && i < seen.size(); i++)
      chk($sformatf("bp_seq%0d", i), seen[i], exp_w[i]);
    $display("back-pressure: %0d handshakes", seen.size());

    // Contention between cores 0 and 1, held continuously
    do_reset();
    text_i[255:128] = BLK1;
    req_i = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      wait_ack(cyc);
      grants[i] = src_o;
      chk($sformatf("cont_grant%0d", i), src_o, (i % 2));
      chk($sformatf("cont_gap%0d", i), cyc, (i == 0) ? 1 : 5);
      chk($sformatf("cont_word0_%0d", i), text_o, (i % 2) ? 32'haaaaaaaa : 32'h00000000);
    end
    $display("contention grants: %0d %0d %0d %0d", grants[0], grants[1], grants[2], grants[3]);
    req_i = '0;
    tick(); tick(); tick(); tick(); tick();

    // Round-robin start after reset with cores 1 and 3 requesting
    do_reset();
    req_i = 4'b1010;
    wait_ack(cyc);
    chk("rr_first", src_o, 2'd1);
    req_i = req_i & ~ack_o;
    wait_ack(cyc);
    chk("rr_second", src_o, 2'd3);
    req_i = '0;
    $display("round-robin start: second grant core %0d", src_o);
    tick(); tick(); tick(); tick();

    // Asynchronous reset in the middle of a block
    do_reset();
    req_i = 4'b0001;
    tick();
    req_i = '0;
    tick(); tick();
    chk("mid_idx_before", word_idx_o, 2'd2);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", valid_o, 1'b0);
    chk("mid_rst_busy", busy_o, 1'b0);
    chk("mid_rst_ack", ack_o, 4'b0000);
    chk("mid_rst_idx", word_idx_o, 2'd0);
    tick();
    rst = 1'b0;
    tick();
    req_i = 4'b0011;
    tick();
    req_i = '0;
    chk("mid_restart_src", src_o, 2'd0);
    chk("mid_restart_idx", word_idx_o, 2'd0);
    chk("mid_restart_text", text_o, 32'h00000000);
    $display("reset mid-stream: restarted on core %0d", src_o);
    tick(); tick(); tick(); tick();

    // Idle stability with ready toggling
    for (int i = 0; i < 20; i++) begin
      ready_i = i[0];
      tick();
      chk("idle_valid", valid_o, 1'b0);
      chk("idle_ack", ack_o, 4'b0000);
      chk("idle_busy", busy_o, 1'b0);
    end
    $display("idle stability: 20 cycles");

    // Randomized traffic with fairness tracking
    do_reset();
    for (int k = 0; k < N; k++) waited[k] = 0;
    for (int t = 0; t < 600; t++) begin
      tick();
      if (ack_o != '0) begin
        for (int k = 0; k < N; k++) begin
          if (ack_o[k]) begin
            chk("fairness", (waited[k] <= N-1), 1'b1);
            waited[k] = 0;
          end else if (req_i[k]) begin
            waited[k]++;
          end
        end
      end
      for (int k = 0; k < N; k++) begin
        if (req_i[k] && ack_o[k]) begin
          if ($urandom_range(3) != 0) req_i[k] = 1'b0;
        end else if (!req_i[k] && $urandom_range(3) == 0) begin
          for (int w = 0; w < 4; w++) text_i[128*k+32*w +: 32] = $urandom;
          req_i[k] = 1'b1;
          waited[k] = 0;
        end
      end
      ready_i = ($urandom_range(3) != 0);
    end
    $display("random traffic: %0d words accepted", seen.size());

    req_i = '0;
    ready_i = 1'b1;
    tick(); tick(); tick(); tick(); tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
